// File: rtl/coproc_sched.sv
// coproc_sched: in-order scheduler for the custom-instruction coprocessor.
// Offloaded instructions are queued at issue and wait there for the core's commit
// or kill. The head entry is then handed to its unit (CNTB or WBITS), and its result
// is returned on the result channel in issue order.
// Optional build macro: COPROC_SCHED_PERF_EN adds the perf_issued_o, perf_killed_o
// and perf_stall_o saturating counters.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready are
// both high. Issue: issue_ready_o depends only on the registered occupancy, and
// issue_accept_o/issue_ls_o are combinational responses to the offered instruction.
// Result: result_valid_o holds, with result_id_o/rd/data/we stable, until a cycle
// with result_ready_i high. Commit and unit_done_i are single-cycle strobes with no
// backpressure.
module coproc_sched #(
  parameter int         DEPTH     = 4,
  parameter int         ID_W      = 4,
  parameter logic [6:0] OPC_CNTB  = 7'h0B,
  parameter logic [6:0] OPC_WBITS = 7'h2B
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_accept_o,
  output logic            issue_ls_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            cntb_start_o,
  output logic            wbits_start_o,
  output logic [31:0]     unit_instr_o,
  input  logic            unit_done_i,
  input  logic [31:0]     unit_data_i,
  input  logic            mem_busy_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [31:0]     result_data_o,
  output logic            result_we_o,
`ifdef COPROC_SCHED_PERF_EN
  output logic [31:0]     perf_issued_o,
  output logic [31:0]     perf_killed_o,
  output logic [31:0]     perf_stall_o,
`endif
  output logic [1:0]      dbg_state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  q_id    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [DEPTH-1:0] q_unit;   // 1 = WBITS, 0 = CNTB
  logic [DEPTH-1:0] q_cmt;
  logic [DEPTH-1:0] q_kill;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic             is_cntb;
  logic             is_wbits;
  logic             full;
  logic             push;
  logic             pop;
  logic             pop_kill;
  logic             head_kill;
  logic             head_cmt;
  logic             new_match;

  // Issue response, head status and queue push/pop decisions
  always_comb begin
    is_cntb        = (issue_instr_i[6:0] == OPC_CNTB);
    is_wbits       = (issue_instr_i[6:0] == OPC_WBITS);
    full           = (count_q == CNT_W'(DEPTH));
    issue_ready_o  = !full;
    issue_accept_o = issue_valid_i && !full && (is_cntb || is_wbits);
    issue_ls_o     = issue_accept_o && is_wbits;
    push           = issue_accept_o;
    head_kill      = q_valid[head_q] && q_kill[head_q];
    head_cmt       = q_valid[head_q] && q_cmt[head_q];
    pop_kill       = (state_q == S_IDLE) && head_kill;
    pop            = pop_kill || ((state_q == S_WB) && result_ready_i);
    new_match      = commit_valid_i && (commit_id_i == issue_id_i);
    dbg_state_o    = state_q;
  end

  // Queue storage: commit/kill marking, tail write and head release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_id[i]    <= '0;
        q_instr[i] <= '0;
      end
      q_valid <= '0;
      q_unit  <= '0;
      q_cmt   <= '0;
      q_kill  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && q_valid[i] && (q_id[i] == commit_id_i)) begin
          if (!commit_kill_i) begin
            q_cmt[i] <= 1'b1;
          end else if (!((PTR_W'(i) == head_q) && (state_q != S_IDLE))) begin
            // A dispatched head is already committed; late kills do not apply.
            q_kill[i] <= 1'b1;
          end
        end
      end
      if (push) begin
        q_valid[tail_q] <= 1'b1;
        q_id[tail_q]    <= issue_id_i;
        q_instr[tail_q] <= issue_instr_i;
        q_unit[tail_q]  <= is_wbits;
        q_cmt[tail_q]   <= new_match && !commit_kill_i;
        q_kill[tail_q]  <= new_match && commit_kill_i;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        q_valid[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head sequencer: dispatch, wait for unit and memory, present the result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cntb_start_o   <= 1'b0;
      wbits_start_o  <= 1'b0;
      unit_instr_o   <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_data_o  <= '0;
      result_we_o    <= 1'b0;
    end else begin
      cntb_start_o  <= 1'b0;
      wbits_start_o <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // A killed head is popped by the queue logic; the FSM just waits.
          if (!head_kill && head_cmt) begin
            cntb_start_o  <= !q_unit[head_q];
            wbits_start_o <= q_unit[head_q];
            unit_instr_o  <= q_instr[head_q];
            result_id_o   <= q_id[head_q];
            result_rd_o   <= q_instr[head_q][11:7];
            result_we_o   <= !q_unit[head_q];
            state_q       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (unit_done_i) begin
            result_data_o <= unit_data_i;
            if (!result_we_o && mem_busy_i) begin
              state_q <= S_MEM;
            end else begin
              state_q        <= S_WB;
              result_valid_o <= 1'b1;
            end
          end
        end
        S_MEM: begin
          if (!mem_busy_i) begin
            state_q        <= S_WB;
            result_valid_o <= 1'b1;
          end
        end
        S_WB: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef COPROC_SCHED_PERF_EN
  // Saturating event counters: accepted issues, killed pops, issue stall cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o <= '0;
      perf_killed_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (push && (perf_issued_o != '1)) perf_issued_o <= perf_issued_o + 32'd1;
      if (pop_kill && (perf_killed_o != '1)) perf_killed_o <= perf_killed_o + 32'd1;
      if (issue_valid_i && !issue_ready_o && (perf_stall_o != '1)) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
